// File: rtl/dmem_access_ctrl.sv
// Load/store controller for a word-wide DataMem.
// Handles byte/half/word access, sub-word read-modify-write and misalignment.
module dmem_access_ctrl #(
    parameter int ADDR_W          = 32,
    parameter bit ERR_ON_MISALIGN = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [31:0]       resp_rdata,
    output logic              resp_err,
    output logic [ADDR_W-1:0] mem_addrIn,
    output logic [31:0]       mem_dataW,
    input  logic [31:0]       mem_dataR,
    output logic              mem_memRW
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RD   = 2'd1;
    localparam logic [1:0] WR   = 2'd2;
    localparam logic [1:0] RESP = 2'd3;

    logic [1:0]        state;
    logic              we_q;
    logic              uns_q;
    logic [1:0]        size_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q;
    logic [31:0]       rdata_q;
    logic              err_q;

    logic              misal;
    logic [1:0]        acc_size;
    logic [ADDR_W-1:0] acc_addr;
    logic [31:0]       shifted;
    logic [7:0]        b;
    logic [15:0]       h;
    logic [31:0]       load_val;
    logic [31:0]       merged;

    always_comb begin
        misal    = 1'b0;
        acc_size = req_size;
        acc_addr = req_addr;
        unique case (req_size)
            2'd0: misal = 1'b0;
            2'd1: misal = req_addr[0];
            2'd2: misal = (req_addr[1:0] != 2'b00);
            2'd3: misal = 1'b1;
        endcase
        // With errors disabled, the reserved size is handled as a word.
        if (!ERR_ON_MISALIGN) begin
            if (req_size == 2'd3) acc_size = 2'd2;
            if (acc_size == 2'd1) acc_addr[0] = 1'b0;
            if (acc_size == 2'd2) acc_addr[1:0] = 2'b00;
        end
    end

    always_comb begin
        shifted  = mem_dataR >> {addr_q[1:0], 3'b000};
        b        = shifted[7:0];
        h        = addr_q[1] ? mem_dataR[31:16] : mem_dataR[15:0];
        load_val = mem_dataR;
        merged   = mem_dataR;
        unique case (size_q)
            2'd0: begin
                load_val = uns_q ? {24'b0, b} : {{24{b[7]}}, b};
                merged[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
            end
            2'd1: begin
                load_val = uns_q ? {16'b0, h} : {{16{h[15]}}, h};
                merged[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
            end
            default: begin
                load_val = mem_dataR;
                merged   = wdata_q;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            we_q    <= 1'b0;
            uns_q   <= 1'b0;
            size_q  <= 2'd0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            unique case (state)
                IDLE: if (req_valid) begin
                    we_q    <= req_we;
                    uns_q   <= req_unsigned;
                    size_q  <= acc_size;
                    addr_q  <= acc_addr;
                    wdata_q <= req_wdata;
                    rdata_q <= '0;
                    err_q   <= 1'b0;
                    if (ERR_ON_MISALIGN && misal) begin
                        err_q <= 1'b1;
                        state <= RESP;
                    end else if (req_we && acc_size == 2'd2) begin
                        state <= WR;
                    end else begin
                        state <= RD;
                    end
                end
                RD: begin
                    if (we_q) begin
                        wdata_q <= merged;
                        state   <= WR;
                    end else begin
                        rdata_q <= load_val;
                        state   <= RESP;
                    end
                end
                WR: state <= RESP;
                RESP: if (resp_ready) state <= IDLE;
            endcase
        end
    end

    // Decoded from state so an async reset kills a pending write at once.
    assign req_ready  = (state == IDLE);
    assign resp_valid = (state == RESP);
    assign resp_rdata = rdata_q;
    assign resp_err   = err_q;
    assign mem_memRW  = (state == WR);
    assign mem_dataW  = (state == WR) ? wdata_q : 32'h0;
    assign mem_addrIn = (state == RD || state == WR) ?
                        {addr_q[ADDR_W-1:2], 2'b00} : '0;

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Directed testbench for dmem_access_ctrl with a behavioural DataMem.
// Each task drives one scenario and checks against hand-computed values.
module tb_dmem_access_ctrl;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [31:0] mem_addrIn;
    logic [31:0] mem_dataW;
    logic [31:0] mem_dataR;
    logic        mem_memRW;

    logic [31:0] mem [0:15];

    int errors = 0;
    int checks = 0;

    int          lat;
    int          wcnt;
    logic [31:0] wd_seen;
    logic [31:0] wa_seen;
    logic [31:0] r_data;
    logic        r_err;

    dmem_access_ctrl #(.ADDR_W(32), .ERR_ON_MISALIGN(1'b1)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_we(req_we), .req_size(req_size),
        .req_unsigned(req_unsigned), .req_addr(req_addr),
        .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata), .resp_err(resp_err),
        .mem_addrIn(mem_addrIn), .mem_dataW(mem_dataW),
        .mem_dataR(mem_dataR), .mem_memRW(mem_memRW)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign mem_dataR = mem[mem_addrIn[5:2]];
    always @(posedge clk) if (mem_memRW) mem[mem_addrIn[5:2]] <= mem_dataW;

    task automatic run_req(input logic we, input logic [1:0] sz,
                           input logic un, input logic [31:0] a,
                           input logic [31:0] wd);
        req_we = we; req_size = sz; req_unsigned = un;
        req_addr = a; req_wdata = wd; req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        lat = 1; wcnt = 0; wd_seen = '0; wa_seen = '0;
        while (!resp_valid && lat < 10) begin
            if (mem_memRW) begin
                wcnt++; wd_seen = mem_dataW; wa_seen = mem_addrIn;
            end
            @(posedge clk); #1;
            lat++;
        end
        checks++;
        if (!resp_valid) begin
            errors++;
            $display("FAIL resp_timeout addr=%h got no resp_valid, need it", a);
        end
        r_data = resp_rdata;
        r_err  = resp_err;
        resp_ready = 1'b1;
        @(posedge clk); #1;
        resp_ready = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        #12;
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL rst_req_ready got %b need 1", req_ready); end
        checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL rst_resp_valid got %b need 0", resp_valid); end
        checks++; if (resp_rdata !== 32'h0) begin errors++; $display("FAIL rst_rdata got %h need 0", resp_rdata); end
        checks++; if (resp_err !== 1'b0) begin errors++; $display("FAIL rst_err got %b need 0", resp_err); end
        checks++; if (mem_memRW !== 1'b0) begin errors++; $display("FAIL rst_memRW got %b need 0", mem_memRW); end
        checks++; if (mem_addrIn !== 32'h0) begin errors++; $display("FAIL rst_addrIn got %h need 0", mem_addrIn); end
        checks++; if (mem_dataW !== 32'h0) begin errors++; $display("FAIL rst_dataW got %h need 0", mem_dataW); end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_word_store;
        run_req(1'b1, 2'd2, 1'b0, 32'h0, 32'ha28b538c);
        checks++; if (wcnt !== 1) begin errors++; $display("FAIL ws_wcnt got %0d need 1", wcnt); end
        checks++; if (wa_seen !== 32'h0) begin errors++; $display("FAIL ws_addr got %h need 0", wa_seen); end
        checks++; if (wd_seen !== 32'ha28b538c) begin errors++; $display("FAIL ws_dataW got %h need a28b538c", wd_seen); end
        checks++; if (lat !== 2) begin errors++; $display("FAIL ws_latency got %0d need 2", lat); end
        checks++; if (r_err !== 1'b0) begin errors++; $display("FAIL ws_err got %b need 0", r_err); end
        checks++; if (r_data !== 32'h0) begin errors++; $display("FAIL ws_rdata got %h need 0", r_data); end
        checks++; if (mem[0] !== 32'ha28b538c) begin errors++; $display("FAIL ws_mem got %h need a28b538c", mem[0]); end
    endtask

    task automatic test_loads;
        logic [1:0]  sz [7];
        logic        un [7];
        logic [31:0] ad [7];
        logic [31:0] ex [7];
        int          wtot;
        sz = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd2, 2'd1, 2'd0};
        un = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        ad = '{32'h3, 32'h3, 32'h2, 32'h0, 32'h0, 32'h2, 32'h1};
        ex = '{32'hffffffa2, 32'h000000a2, 32'hffffa28b, 32'h0000538c,
               32'ha28b538c, 32'h0000a28b, 32'h00000053};
        wtot = 0;
        for (int i = 0; i < 7; i++) begin
            run_req(1'b0, sz[i], un[i], ad[i], 32'h0);
            wtot += wcnt;
            checks++;
            if (r_data !== ex[i]) begin
                errors++;
                $display("FAIL load_%0d got %h need %h", i, r_data, ex[i]);
            end
            checks++;
            if (lat !== 2) begin
                errors++;
                $display("FAIL load_lat_%0d got %0d need 2", i, lat);
            end
        end
        checks++; if (wtot !== 0) begin errors++; $display("FAIL load_memRW got %0d writes need 0", wtot); end
    endtask

    task automatic test_subword_store;
        run_req(1'b1, 2'd0, 1'b0, 32'h1, 32'h000000ff);
        checks++; if (wcnt !== 1) begin errors++; $display("FAIL sb_wcnt got %0d need 1", wcnt); end
        checks++; if (wd_seen !== 32'ha28bff8c) begin errors++; $display("FAIL sb_dataW got %h need a28bff8c", wd_seen); end
        checks++; if (lat !== 3) begin errors++; $display("FAIL sb_latency got %0d need 3", lat); end
        run_req(1'b0, 2'd2, 1'b0, 32'h0, 32'h0);
        checks++; if (r_data !== 32'ha28bff8c) begin errors++; $display("FAIL sb_readback got %h need a28bff8c", r_data); end
        run_req(1'b1, 2'd1, 1'b0, 32'h2, 32'hcafe1234);
        checks++; if (wd_seen !== 32'h1234ff8c) begin errors++; $display("FAIL sh_dataW got %h need 1234ff8c", wd_seen); end
        run_req(1'b0, 2'd2, 1'b0, 32'h0, 32'h0);
        checks++; if (r_data !== 32'h1234ff8c) begin errors++; $display("FAIL sh_readback got %h need 1234ff8c", r_data); end
    endtask

    task automatic test_misalign;
        run_req(1'b0, 2'd1, 1'b0, 32'h1, 32'h0);
        checks++; if (lat !== 1) begin errors++; $display("FAIL mis_latency got %0d need 1", lat); end
        checks++; if (r_err !== 1'b1) begin errors++; $display("FAIL mis_err got %b need 1", r_err); end
        checks++; if (r_data !== 32'h0) begin errors++; $display("FAIL mis_rdata got %h need 0", r_data); end
        checks++; if (wcnt !== 0) begin errors++; $display("FAIL mis_wcnt got %0d need 0", wcnt); end
        run_req(1'b0, 2'd3, 1'b0, 32'h0, 32'h0);
        checks++; if (r_err !== 1'b1) begin errors++; $display("FAIL size3_err got %b need 1", r_err); end
        run_req(1'b1, 2'd2, 1'b0, 32'h2, 32'h55555555);
        checks++; if (r_err !== 1'b1) begin errors++; $display("FAIL mis_st_err got %b need 1", r_err); end
        checks++; if (wcnt !== 0) begin errors++; $display("FAIL mis_st_wcnt got %0d need 0", wcnt); end
        checks++; if (mem[0] !== 32'h1234ff8c) begin errors++; $display("FAIL mis_st_mem got %h need 1234ff8c", mem[0]); end
    endtask

    task automatic test_back_to_back;
        int n;
        req_we = 1'b0; req_size = 2'd0; req_unsigned = 1'b1;
        req_addr = 32'h3; req_wdata = 32'h0; req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        n = 0;
        while (!resp_valid && n < 10) begin @(posedge clk); #1; n++; end
        req_valid = 1'b1; req_size = 2'd2; req_unsigned = 1'b0; req_addr = 32'h0;
        for (int i = 0; i < 3; i++) begin
            checks++; if (resp_valid !== 1'b1) begin errors++; $display("FAIL hold_valid_%0d got %b need 1", i, resp_valid); end
            checks++; if (resp_rdata !== 32'h00000012) begin errors++; $display("FAIL hold_rdata_%0d got %h need 00000012", i, resp_rdata); end
            checks++; if (resp_err !== 1'b0) begin errors++; $display("FAIL hold_err_%0d got %b need 0", i, resp_err); end
            checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL hold_ready_%0d got %b need 0", i, req_ready); end
            @(posedge clk); #1;
        end
        resp_ready = 1'b1;
        @(posedge clk); #1;
        resp_ready = 1'b0;
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready got %b need 1", req_ready); end
        checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL b2b_valid got %b need 0", resp_valid); end
        @(posedge clk); #1;
        req_valid = 1'b0;
        checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL b2b_accept got ready=%b need 0", req_ready); end
        n = 0;
        while (!resp_valid && n < 10) begin @(posedge clk); #1; n++; end
        checks++; if (resp_rdata !== 32'h1234ff8c) begin errors++; $display("FAIL b2b_rdata got %h need 1234ff8c", resp_rdata); end
        resp_ready = 1'b1;
        @(posedge clk); #1;
        resp_ready = 1'b0;
    endtask

    task automatic test_reset_in_wr;
        mem[1] = 32'h11223344;
        req_we = 1'b1; req_size = 2'd2; req_unsigned = 1'b0;
        req_addr = 32'h4; req_wdata = 32'hdeadbeef; req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        checks++; if (mem_memRW !== 1'b1) begin errors++; $display("FAIL wr_memRW got %b need 1", mem_memRW); end
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (mem_memRW !== 1'b0) begin errors++; $display("FAIL rstwr_memRW got %b need 0", mem_memRW); end
        @(posedge clk); #1;
        checks++; if (mem[1] !== 32'h11223344) begin errors++; $display("FAIL rstwr_mem got %h need 11223344", mem[1]); end
        checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL rstwr_valid got %b need 0", resp_valid); end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL rstwr_ready got %b need 1", req_ready); end
        checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL rstwr_valid2 got %b need 0", resp_valid); end
    endtask

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = 32'h0;
        req_valid = 1'b0; req_we = 1'b0; req_size = 2'd0;
        req_unsigned = 1'b0; req_addr = '0; req_wdata = '0;
        resp_ready = 1'b0;
        test_reset();
        test_word_store();
        test_loads();
        test_subword_store();
        test_misalign();
        test_back_to_back();
        test_reset_in_wr();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/dmem_access_ctrl.md
Name: dmem_access_ctrl

Overview:
- Initiator-side controller that drives the data memory (DataMem) on behalf of the core's load/store path.
- Accepts byte/half/word load and store requests over a valid/ready interface.
- Issues word-wide accesses to DataMem; sub-word stores use read-modify-write.
- Returns sign/zero-extended load data, or an error on misalignment, over a held response handshake.

Parameters:
ADDR_W, 32, width of request and memory address buses
ERR_ON_MISALIGN, 1, 1 = misaligned request returns resp_err with no memory access; 0 = low address bits force-aligned and access proceeds

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
req_valid  input  1  request present
req_ready  output  1  request accepted when req_valid && req_ready at rising edge
req_we  input  1  1 = store, 0 = load
req_size  input  2  0 = byte, 1 = half, 2 = word, 3 = reserved (treated as misaligned)
req_unsigned  input  1  loads: 1 = zero-extend, 0 = sign-extend
req_addr  input  ADDR_W  byte address
req_wdata  input  32  store data, right-aligned (bits [7:0] for byte, [15:0] for half)
resp_valid  output  1  response available
resp_ready  input  1  response consumed when resp_valid && resp_ready at rising edge
resp_rdata  output  32  load result; 0 for stores and errors
resp_err  output  1  misaligned or reserved-size request
mem_addrIn  output  ADDR_W  word-aligned byte address to DataMem addrIn; bits [1:0] always 0
mem_dataW  output  32  write data to DataMem dataW
mem_dataR  input  32  DataMem dataR; combinational read of mem_addrIn
mem_memRW  output  1  DataMem memRW; 1 = write on next rising clk edge

Behaviour:
- DataMem contract: read is combinational from addrIn; write commits the full 32-bit word at the rising edge when memRW=1; little-endian, byte lane = addr[1:0].
- FSM states:
  - IDLE
  - RD: read cycle
  - WR: write cycle
  - RESP: hold response
- Reset (async, rst_n=0):
  - State goes to IDLE immediately.
  - req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0.
  - mem_memRW=0, mem_addrIn=0, mem_dataW=0.
  - mem_memRW is decoded from the state register, so it drops without a clock edge.
- IDLE:
  - req_ready=1.
  - On accept, latch we, size, unsigned, addr and wdata.
  - Misaligned (half with addr[0]=1, word with addr[1:0]!=0, or size=3) and ERR_ON_MISALIGN=1: go to RESP with resp_err=1, no memory access.
  - Load or sub-word store: go to RD. Word store: go to WR.
- RD:
  - mem_addrIn={addr[ADDR_W-1:2],2'b00}, mem_memRW=0.
  - At the edge, capture mem_dataR.
  - Load: extract the lane and extend into the response register, then go to RESP.
  - Sub-word store: merge the store bytes into the captured word (other bytes unchanged) into the write register, then go to WR.
- WR:
  - mem_memRW=1 for exactly this one cycle; mem_addrIn as in RD.
  - mem_dataW = merged word, or wdata for word stores.
  - Next state: RESP.
- RESP:
  - resp_valid=1; resp_rdata and resp_err held stable.
  - On resp_ready go to IDLE, with req_ready=1 in the following cycle.
- req_ready=0 in all states except IDLE; no request overlap.
- Outside WR, mem_memRW=0 and mem_dataW=0.
- Latency from accept edge to resp_valid high:
  - load: 2 cycles
  - word store: 2 cycles
  - sub-word store: 3 cycles
  - error: 1 cycle
- Extension:
  - byte signed: {24{b[7]},b}; byte unsigned: {24'b0,b}
  - half signed: {16{h[15]},h}; half unsigned: {16'b0,h}
  - word: req_unsigned ignored
- Reset mid-operation: any in-flight request is dropped, no response is produced, and a write in progress is aborted before its edge.
- resp_ready asserted while resp_valid=0 is ignored.

Test Plan:
1. DataMem zeroed; word store addr 0x0 data 0xa28b538c -> mem_memRW high exactly 1 cycle with mem_addrIn=0x0 and mem_dataW=0xa28b538c; resp_valid 2 cycles after accept; resp_err=0; resp_rdata=0.
2. Word 0 = 0xa28b538c; loads:
   - byte signed @0x3 -> 0xffffffa2
   - byte unsigned @0x3 -> 0x000000a2
   - half signed @0x2 -> 0xffffa28b
   - half signed @0x0 -> 0x0000538c
   - word @0x0 -> 0xa28b538c
   - mem_memRW stays 0 throughout.
3. Word 0 = 0xa28b538c; byte store @0x1 wdata 0x000000ff -> RD then WR; mem_dataW=0xa28bff8c for one cycle; resp 3 cycles after accept; subsequent word load @0x0 returns 0xa28bff8c.
4. Half load @0x1 with ERR_ON_MISALIGN=1 -> resp_valid next cycle with resp_err=1 and resp_rdata=0; mem_memRW never asserted. Also size=3 @0x0 -> resp_err=1.
5. resp_ready held low 3 cycles after resp_valid -> resp_valid/resp_rdata/resp_err stable, req_ready=0, and a concurrent req_valid is not accepted until the cycle after the resp handshake.
6. rst_n pulled low mid-cycle while in WR -> mem_memRW falls to 0 without a clock edge; memory word unchanged; resp_valid=0; req_ready=1 after release.
